lcd_hex_writer: RTL

Consumer end of the 32-bit display value the UI handler produces. It initialises the 16x2 HD44780-compatible character LCD. After that it writes the value as 8 uppercase hex characters at line 1, columns 0-7, and rewrites only when the value changes. It sits between the UI handler's 32-bit LCD data output and the board LCD pins.

---
 rtl/lcd_pkg.sv | 48 ++++
 rtl/lcd_byte_xfer.sv | 106 ++++++++++
 rtl/lcd_hex_writer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the hex LCD writer.
// Covers the HD44780 command bytes and the nibble-to-ASCII mapping.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_ADDR_L1  = 8'h80;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_INIT,
        S_IDLE,
        S_ADDR,
        S_CHAR
    } state_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_PULSE,
        X_WAIT
    } xfer_phase_t;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        unique case (1'b1)
            (n <= 4'd9): return 8'h30 + {4'h0, n};
            default:     return 8'h37 + {4'h0, n};
        endcase
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        unique case (i)
            2'd0: return LCD_FUNC_SET;
            2'd1: return LCD_DISP_ON;
            2'd2: return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

    // Index 0 selects the most significant nibble.
    function automatic logic [3:0] nibble_at(input logic [31:0] v,
                                             input logic [2:0] i);
        return v[{~i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/lcd_byte_xfer.sv
// One LCD bus write: setup, EN strobe, then settle time.
// DATA/RS stay latched from start until the next start.
module lcd_byte_xfer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYCLES      = 2,
    parameter int EN_PULSE_CYCLES   = 25,
    parameter int WAIT_CYCLES       = 2500,
    parameter int CLEAR_WAIT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    input  logic       cmd_long,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       done
);

    localparam int M1   = (SETUP_CYCLES > EN_PULSE_CYCLES) ?
                          SETUP_CYCLES : EN_PULSE_CYCLES;
    localparam int M2   = (WAIT_CYCLES > CLEAR_WAIT_CYCLES) ?
                          WAIT_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    xfer_phase_t   phase, phase_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          long_q, long_d;
    logic [CW-1:0] wait_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase  <= X_IDLE;
            cnt    <= '0;
            data_q <= '0;
            rs_q   <= 1'b0;
            long_q <= 1'b0;
        end else begin
            phase  <= phase_d;
            cnt    <= cnt_d;
            data_q <= data_d;
            rs_q   <= rs_d;
            long_q <= long_d;
        end
    end

    assign wait_last = long_q ? CW'(CLEAR_WAIT_CYCLES - 1)
                              : CW'(WAIT_CYCLES - 1);

    always_comb begin
        phase_d = phase;
        cnt_d   = cnt;
        data_d  = data_q;
        rs_d    = rs_q;
        long_d  = long_q;
        done    = 1'b0;
        unique case (phase)
            X_IDLE: begin
                if (start) begin
                    phase_d = X_SETUP;
                    cnt_d   = '0;
                    data_d  = cmd_data;
                    rs_d    = cmd_rs;
                    long_d  = cmd_long;
                end
            end
            X_SETUP: begin
                if (cnt == CW'(SETUP_CYCLES - 1)) begin
                    phase_d = X_PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            X_PULSE: begin
                if (cnt == CW'(EN_PULSE_CYCLES - 1)) begin
                    phase_d = X_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            X_WAIT: begin
                if (cnt == wait_last) begin
                    done    = 1'b1;
                    phase_d = X_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: phase_d = X_IDLE;
        endcase
    end

    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_en   = (phase == X_PULSE);

endmodule

// File: rtl/lcd_hex_writer.sv
// Initialises a 16x2 character LCD, then shows value_in as 8 hex digits
// on line 1, rewriting only when the value differs from the last frame.
module lcd_hex_writer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int SETUP_CYCLES      = 2,
    parameter int EN_PULSE_CYCLES   = 25,
    parameter int WAIT_CYCLES       = 2500,
    parameter int CLEAR_WAIT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value_in,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        LCD_ON,
    output logic        LCD_BLON,
    output logic        busy
);

    localparam int PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;

    state_t        state, state_d;
    logic [PW-1:0] wait_cnt, wait_cnt_d;
    logic [2:0]    idx, idx_d;
    logic          issued, issued_d;
    logic [31:0]   snapshot, snapshot_d;
    logic          frame_valid, frame_valid_d;

    logic          start;
    logic          x_rs;
    logic [7:0]    x_data;
    logic          x_long;
    logic          x_done;

    lcd_byte_xfer #(
        .SETUP_CYCLES      (SETUP_CYCLES),
        .EN_PULSE_CYCLES   (EN_PULSE_CYCLES),
        .WAIT_CYCLES       (WAIT_CYCLES),
        .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES)
    ) u_xfer (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cmd_rs   (x_rs),
        .cmd_data (x_data),
        .cmd_long (x_long),
        .lcd_data (LCD_DATA),
        .lcd_rs   (LCD_RS),
        .lcd_en   (LCD_EN),
        .done     (x_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_POWERUP;
            wait_cnt    <= '0;
            idx         <= '0;
            issued      <= 1'b0;
            snapshot    <= '0;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_d;
            wait_cnt    <= wait_cnt_d;
            idx         <= idx_d;
            issued      <= issued_d;
            snapshot    <= snapshot_d;
            frame_valid <= frame_valid_d;
        end
    end

    always_comb begin
        state_d       = state;
        wait_cnt_d    = wait_cnt;
        idx_d         = idx;
        issued_d      = issued;
        snapshot_d    = snapshot;
        frame_valid_d = frame_valid;
        start         = 1'b0;
        x_rs          = 1'b0;
        x_data        = 8'h00;
        x_long        = 1'b0;
        // Sending states fire start once, then wait for done.
        if ((state == S_INIT || state == S_ADDR || state == S_CHAR)
            && !issued) begin
            start    = 1'b1;
            issued_d = 1'b1;
        end
        unique case (state)
            S_POWERUP: begin
                if (wait_cnt == PW'(POWERUP_CYCLES - 1)) begin
                    state_d    = S_INIT;
                    wait_cnt_d = '0;
                    idx_d      = '0;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            S_INIT: begin
                x_data = init_cmd(idx[1:0]);
                x_long = (idx == 3'd2);
                if (x_done) begin
                    issued_d = 1'b0;
                    if (idx == 3'd3) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (!frame_valid || value_in != snapshot) begin
                    snapshot_d = value_in;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                x_data = LCD_ADDR_L1;
                if (x_done) begin
                    issued_d = 1'b0;
                    state_d  = S_CHAR;
                    idx_d    = '0;
                end
            end
            S_CHAR: begin
                x_rs   = 1'b1;
                x_data = hex_to_ascii(nibble_at(snapshot, idx));
                if (x_done) begin
                    issued_d = 1'b0;
                    if (idx == 3'd7) begin
                        frame_valid_d = 1'b1;
                        state_d       = S_IDLE;
                        idx_d         = '0;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            default: state_d = S_POWERUP;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;

endmodule
